// File: rtl/rv32i_types.sv
// Shared RV32 out-of-order core types: issue/CDB payloads and multiply-unit encodings.
package rv32i_types;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ROB_W  = 4;
    localparam int unsigned PHYS_W = 6;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
    } rvfi_data_t;

    typedef struct packed {
        logic [31:0]       instr;
        logic [31:0]       ps1_v;
        logic [31:0]       ps2_v;
        rvfi_data_t        rvfi_data;
        logic [ROB_W-1:0]  rob_num;
        logic [PHYS_W-1:0] pd_s;
        logic [31:0]       pc;
    } issue_fu_data_t;

    typedef struct packed {
        logic [PHYS_W-1:0] pd_s;
        logic [ROB_W-1:0]  rob_num;
        logic [31:0]       rd_v;
        rvfi_data_t        rvfi_data;
    } fu_result_t;

    typedef enum logic [2:0] {
        mul    = 3'b000,
        mulh   = 3'b001,
        mulhsu = 3'b010,
        mulhu  = 3'b011
    } mult_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } mult_state_t;

endpackage

// File: rtl/mult_fu_shift_add.sv
// Unsigned XLEN x XLEN iterative shift-add multiplier retiring BITS_PER_CYCLE bits per step.
module mult_shift_add
    import rv32i_types::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic [2*XLEN-1:0] o_acc_next,
    output logic              o_last
);
    localparam int unsigned ITERS = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_a;
    logic [XLEN-1:0]   r_b;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] w_partial;

    // r_a is pre-shifted each step, so partial k only needs a further shift by k.
    always_comb begin
        w_partial = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (r_b[k]) begin
                w_partial = w_partial + (r_a << k);
            end
        end
    end

    assign o_acc_next = r_acc + w_partial;
    assign o_last     = (r_cnt == LAST_CNT);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_acc <= '0;
            r_a   <= {{XLEN{1'b0}}, i_a};
            r_b   <= i_b;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= o_acc_next;
            r_a   <= r_a << BITS_PER_CYCLE;
            r_b   <= r_b >> BITS_PER_CYCLE;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mult_fu.sv
// RV32M multiply functional unit: sign handling, tag latching, FSM and CDB req/ack around
// the shift-add datapath.
module mult_fu
    import rv32i_types::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           start,
    input  issue_fu_data_t issue_data,
    output logic           busy,
    output logic           cdb_req,
    input  logic           cdb_ack,
    output fu_result_t     cdb_data
);
    mult_state_t r_state;
    mult_state_t w_state_d;
    logic        r_neg;
    logic        r_hi;
    fu_result_t  r_result;

    logic        w_load;
    logic        w_step;
    logic        w_last;
    logic        w_sign_a;
    logic        w_sign_b;
    logic        w_neg;
    logic        w_hi;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_rd_v;
    logic [63:0] w_acc_next;
    logic [63:0] w_prod;
    rvfi_data_t  w_rvfi;
    logic        w_unused;

    always_comb begin
        w_sign_a = 1'b0;
        w_sign_b = 1'b0;
        w_hi     = 1'b1;
        case (issue_data.instr[14:12])
            mulh: begin
                w_sign_a = 1'b1;
                w_sign_b = 1'b1;
            end
            mulhsu:  w_sign_a = 1'b1;
            mulhu:   w_hi = 1'b1;
            default: w_hi = 1'b0;
        endcase
    end

    // Magnitudes are plain 32-bit negations; -2^31 wraps to 0x80000000, which is its magnitude.
    assign w_neg   = (w_sign_a & issue_data.ps1_v[31]) ^ (w_sign_b & issue_data.ps2_v[31]);
    assign w_mag_a = (w_sign_a && issue_data.ps1_v[31]) ? (32'd0 - issue_data.ps1_v)
                                                        : issue_data.ps1_v;
    assign w_mag_b = (w_sign_b && issue_data.ps2_v[31]) ? (32'd0 - issue_data.ps2_v)
                                                        : issue_data.ps2_v;
    assign w_prod  = r_neg ? (64'd0 - w_acc_next) : w_acc_next;
    assign w_rd_v  = r_hi ? w_prod[63:32] : w_prod[31:0];

    always_comb begin
        w_rvfi           = issue_data.rvfi_data;
        w_rvfi.rs1_rdata = issue_data.ps1_v;
        w_rvfi.rs2_rdata = issue_data.ps2_v;
    end

    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_d = MUL;
                    w_load    = 1'b1;
                end
            end
            MUL: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                if (cdb_ack) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
        if (flush) begin
            w_state_d = IDLE;
            w_load    = 1'b0;
            w_step    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_neg    <= 1'b0;
            r_hi     <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_load) begin
                r_neg              <= w_neg;
                r_hi               <= w_hi;
                r_result.pd_s      <= issue_data.pd_s;
                r_result.rob_num   <= issue_data.rob_num;
                r_result.rd_v      <= '0;
                r_result.rvfi_data <= w_rvfi;
            end
            if (w_step && w_last) begin
                r_result.rd_v               <= w_rd_v;
                r_result.rvfi_data.rd_wdata <= w_rd_v;
            end
        end
    end

    mult_shift_add #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_datapath (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_a       (w_mag_a),
        .i_b       (w_mag_b),
        .o_acc_next(w_acc_next),
        .o_last    (w_last)
    );

    assign busy     = (r_state != IDLE);
    assign cdb_req  = (r_state == DONE);
    assign cdb_data = r_result;

    // pc and the non-funct3 instruction bits travel with rvfi_data, not through this unit.
    assign w_unused = ^{issue_data.instr[31:15], issue_data.instr[11:0], issue_data.pc};

endmodule

// File: tb/tb_mult_fu.sv
// Self-checking bench for mult_fu: one instance per BITS_PER_CYCLE (1, 2, 4), table vectors,
// directed handshake/flush/reset sequences and random ops against a 64-bit product model.
module tb_mult_fu;
    import rv32i_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           start_s [3];
    logic           flush_s [3];
    logic           ack_s   [3];
    logic           busy_s  [3];
    logic           req_s   [3];
    issue_fu_data_t id_s    [3];
    fu_result_t     cd_s    [3];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mult_fu #(
            .BITS_PER_CYCLE(1 << g)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush_s[g]),
            .start     (start_s[g]),
            .issue_data(id_s[g]),
            .busy      (busy_s[g]),
            .cdb_req   (req_s[g]),
            .cdb_ack   (ack_s[g]),
            .cdb_data  (cd_s[g])
        );
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_res(input string name, input fu_result_t act, input fu_result_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Product of the operands extended per their signedness; RV32M picks the low or high half.
    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3) ? p[63:32] : p[31:0];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with unit u idle. flush_at: -1 none, >=1 flush at that MUL sample,
    // -2 flush together with the ack in DONE.
    task automatic run_op(input int u, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int ackd, input int flush_at,
                          input logic [31:0] exp_rd, input string tag);
        issue_fu_data_t d;
        fu_result_t     e;
        int             n;
        int             lat;
        int             bcnt;
        logic           seen;
        string          nm;
        n  = 32 >> u;
        nm = $sformatf("u%0d_%s", u, tag);
        d.instr               = $urandom;
        d.instr[14:12]        = f3;
        d.ps1_v               = a;
        d.ps2_v               = b;
        d.rob_num             = ROB_W'($urandom);
        d.pd_s                = PHYS_W'($urandom);
        d.pc                  = $urandom;
        d.rvfi_data.order     = {$urandom, $urandom};
        d.rvfi_data.inst      = d.instr;
        d.rvfi_data.rs1_addr  = 5'($urandom);
        d.rvfi_data.rs2_addr  = 5'($urandom);
        d.rvfi_data.rs1_rdata = $urandom;
        d.rvfi_data.rs2_rdata = $urandom;
        d.rvfi_data.rd_addr   = 5'($urandom);
        d.rvfi_data.rd_wdata  = $urandom;
        d.rvfi_data.pc_rdata  = d.pc;
        d.rvfi_data.pc_wdata  = d.pc + 32'd4;
        e.pd_s                = d.pd_s;
        e.rob_num             = d.rob_num;
        e.rd_v                = exp_rd;
        e.rvfi_data           = d.rvfi_data;
        e.rvfi_data.rs1_rdata = a;
        e.rvfi_data.rs2_rdata = b;
        e.rvfi_data.rd_wdata  = exp_rd;

        chk({nm, "_idle_at_start"}, 64'(busy_s[u]), 64'd0);
        id_s[u]    = d;
        start_s[u] = 1'b1;
        @(negedge clk);
        start_s[u] = 1'b0;
        id_s[u]    = issue_fu_data_t'(~d);
        bcnt = 0;
        for (lat = 0; lat < 200; lat++) begin
            if (busy_s[u]) bcnt++;
            if (flush_at >= 0 && lat == flush_at) break;
            if (req_s[u]) break;
            @(negedge clk);
        end

        if (flush_at >= 0 && lat == flush_at) begin
            chk({nm, "_req_before_flush"}, 64'(req_s[u]), 64'd0);
            flush_s[u] = 1'b1;
            @(negedge clk);
            flush_s[u] = 1'b0;
            chk({nm, "_busy_after_flush"}, 64'(busy_s[u]), 64'd0);
            seen = 1'b0;
            repeat (n + 2) begin
                if (req_s[u]) seen = 1'b1;
                @(negedge clk);
            end
            chk({nm, "_no_req_flushed"}, 64'(seen), 64'd0);
            return;
        end

        chk({nm, "_latency"}, 64'(lat), 64'(n));
        if (lat >= 200) return;

        for (int k = 0; k <= ackd; k++) begin
            if (k > 0 && busy_s[u]) bcnt++;
            chk({nm, "_req_held"}, 64'(req_s[u]), 64'd1);
            chk({nm, "_rd_v"}, 64'(cd_s[u].rd_v), 64'(exp_rd));
            chk_res({nm, "_cdb_data"}, cd_s[u], e);
            if (k == ackd) begin
                ack_s[u] = 1'b1;
                if (flush_at == -2) flush_s[u] = 1'b1;
            end
            @(negedge clk);
        end
        ack_s[u]   = 1'b0;
        flush_s[u] = 1'b0;
        chk({nm, "_req_after_ack"}, 64'(req_s[u]), 64'd0);
        chk({nm, "_busy_after_ack"}, 64'(busy_s[u]), 64'd0);
        chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(n + 1 + ackd));
    endtask

    initial begin
        vec_t        tbl[10];
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int          fl;
        int          n;

        tbl[0] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        tbl[1] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        tbl[2] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[3] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[4] = '{3'b000, 32'h0000_0003, 32'hFFFF_FFF9, 32'hFFFF_FFEB};
        tbl[5] = '{3'b101, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A};
        tbl[6] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
        tbl[7] = '{3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
        tbl[8] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[9] = '{3'b011, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};

        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            start_s[u] = 1'b0;
            flush_s[u] = 1'b0;
            ack_s[u]   = 1'b0;
            id_s[u]    = '0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d_rst_busy", u), 64'(busy_s[u]), 64'd0);
            chk($sformatf("u%0d_rst_req", u), 64'(req_s[u]), 64'd0);
            chk($sformatf("u%0d_rst_cdb_zero", u), 64'(cd_s[u] == '0), 64'd1);
        end
        rst = 1'b1;
        @(negedge clk);

        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < 10; i++) begin
                run_op(u, tbl[i].f3, tbl[i].a, tbl[i].b, 0, -1, tbl[i].exp,
                       $sformatf("tbl%0d", i));
            end
        end

        // Long ack hold, then back-to-back issue the cycle after busy falls.
        run_op(0, 3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 10, -1,
               ref_mul(3'b011, 32'h1234_5678, 32'h9ABC_DEF0), "hold");
        run_op(0, 3'b000, 32'd5, 32'd6, 0, -1, 32'd30, "b2b");

        for (int u = 0; u < 3; u++) begin
            run_op(u, 3'b001, 32'hCAFE_F00D, 32'h1357_9BDF, 0, (u == 2) ? 3 : 5, 32'd0, "fl_mul");
            run_op(u, 3'b000, 32'd3, 32'hFFFF_FFF9, 0, -1, 32'hFFFF_FFEB, "after_fl_mul");
            run_op(u, 3'b001, 32'hCAFE_F00D, 32'h1357_9BDF, 0, -2,
                   ref_mul(3'b001, 32'hCAFE_F00D, 32'h1357_9BDF), "fl_done");
            run_op(u, 3'b000, 32'd3, 32'hFFFF_FFF9, 0, -1, 32'hFFFF_FFEB, "after_fl_done");
        end

        // Reset mid-MUL, then reset coinciding with start.
        id_s[0]    = '0;
        id_s[0].ps1_v = 32'd9;
        id_s[0].ps2_v = 32'd9;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("u0_busy_before_rst", 64'(busy_s[0]), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("u0_rst_mid_busy", 64'(busy_s[0]), 64'd0);
        chk("u0_rst_mid_req", 64'(req_s[0]), 64'd0);
        chk("u0_rst_mid_cdb_zero", 64'(cd_s[0] == '0), 64'd1);
        start_s[0] = 1'b1;
        @(negedge clk);
        rst        = 1'b1;
        start_s[0] = 1'b0;
        @(negedge clk);
        chk("u0_rst_start_ignored", 64'(busy_s[0]), 64'd0);
        run_op(0, 3'b000, 32'd3, 32'hFFFF_FFF9, 0, -1, 32'hFFFF_FFEB, "after_rst");

        for (int u = 0; u < 3; u++) begin
            n = 32 >> u;
            repeat (300) begin
                f3 = 3'($urandom_range(0, 7));
                a  = pick();
                b  = pick();
                fl = -1;
                if ($urandom_range(0, 7) == 0) begin
                    fl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n - 1)) : -2;
                end
                run_op(u, f3, a, b, int'($urandom_range(0, 5)), fl, ref_mul(f3, a, b), "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
